serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sclr  input  1  synchronous clear; highest synchronous priority.
REQ-006 en  input  1  bit-strobe; serial_in and start sampled only when en=1.
REQ-007 start  input  1  marks the current serial_in bit as the first bit of a frame.
REQ-008 serial_in  input  1  serial data, one bit per enabled cycle.
REQ-009 data_ready  input  1  consumer accepts data_out when data_valid=1.
REQ-010 data_out  output  WIDTH  last completed word, registered.
REQ-011 data_valid  output  1  data_out holds an unconsumed word.
REQ-012 busy  output  1  frame in progress (state SHIFT).
REQ-013 overrun  output  1  sticky: a completed word was dropped.
REQ-014 frame_err  output  1  sticky: start seen mid-frame.

Function
REQ-015 States: IDLE, SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-016 IDLE, en=1 and start=1: capture serial_in as bit 1 of the frame, bit count=1, go to SHIFT; otherwise stay in IDLE and ignore serial_in.
REQ-017 SHIFT, en=1 and start=0: shift serial_in in and increment the count; en=0 holds all state (stall, unlimited length).
REQ-018 Shift direction: MSB_FIRST=1 shifts left, new bit entering the LSB; MSB_FIRST=0 shifts right, new bit entering the MSB.
REQ-019 On the edge capturing bit WIDTH: the completed word is offered to the output register and the state returns to IDLE; data_valid is visible the cycle after the last bit (latency 1).
REQ-020 SHIFT, en=1 and start=1: set frame_err, discard the partial word, and restart with this bit as bit 1 (count=1, stay SHIFT).
REQ-021 Handshake: data_valid=1 and data_ready=1 at an edge consumes the word; data_valid clears unless a new word completes on the same edge.
REQ-022 Completion with data_valid=0, or with data_valid=1 and data_ready=1: data_out SHALL take the new word and data_valid=1; overrun SHALL be unchanged.
REQ-023 Completion with data_valid=1 and data_ready=0: the new word SHALL be dropped, data_out and data_valid unchanged, and overrun set.
REQ-024 data_out SHALL change only on completion per REQ-022, and SHALL NOT change on consume.
REQ-025 overrun and frame_err SHALL clear only on rst_n or sclr.
REQ-026 sclr=1 at an edge: state IDLE, count 0, shift register 0, data_out 0, data_valid/overrun/frame_err 0, regardless of en/start/data_ready.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, count 0, shift register 0, data_out 0, data_valid 0, busy 0, overrun 0, frame_err 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word; after release the block waits for a new start.
REQ-029 While rst_n=0, all inputs SHALL be ignored.

Verification (WIDTH=8, MSB_FIRST=1 unless stated)
REQ-030 Test 1: en=1; bits 1,0,1,0,0,1,0,1, start on the first bit -> data_out=0xA5, data_valid=1 the cycle after the 8th bit; busy=1 during bits 2-8 and 0 after.
REQ-031 Test 2: as Test 1 with en=0 for 3 cycles after bit 4 -> data_out=0xA5, with data_valid delayed exactly 3 cycles.
REQ-032 Test 3: receive 0x3C and hold data_ready=0, then receive 0xC3 -> data_out=0x3C, overrun=1; then pulse data_ready -> data_valid=0 and overrun stays 1.
REQ-033 Test 4: receive 0x3C, then 0x81, with data_ready=1 on the 0x81 completion edge -> data_out=0x81, data_valid=1, overrun=0.
REQ-034 Test 5: 4 bits, then start with 0xF0 -> frame_err=1, data_out=0xF0; then sclr -> all outputs 0. With MSB_FIRST=0, receiving 0xA5 LSB-first -> data_out=0xA5.
REQ-035 Test 6: rst_n=0 between clock edges after bit 5 -> all outputs 0 before the next edge; after release, bits without start are ignored (data_valid stays 0).

Source files
------------

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits per frame, gated by a
// bit strobe, and presents each completed word through a valid/ready register
// with sticky overrun and framing-error flags.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             en,
    input  logic             start,
    input  logic             serial_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   first_word;
    logic [WIDTH-1:0]   shifted;
    logic               complete;
    logic               frame_err_set;

    assign busy = (state_q == SHIFT);

    // Candidate shift-register values: a fresh frame seeded with the current
    // bit, or the running word with the current bit appended.
    always_comb begin
        first_word = '0;
        if (MSB_FIRST != 0) begin
            first_word[0] = serial_in;
            shifted       = {shreg_q[WIDTH-2:0], serial_in};
        end else begin
            first_word[WIDTH-1] = serial_in;
            shifted             = {serial_in, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: frame start, restart on a mid-frame start, shifting,
    // and completion when the final bit arrives.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        complete      = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && start) begin
                    shreg_d = first_word;
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (start) begin
                        // A start inside a frame abandons the partial word.
                        frame_err_set = 1'b1;
                        shreg_d       = first_word;
                        cnt_d         = CNT_ONE;
                    end else if (cnt_q == LAST_CNT) begin
                        complete = 1'b1;
                        shreg_d  = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // State, bit counter and shift register; sclr returns to an empty IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (sclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Output word register with valid/ready handshake; a completed word that
    // finds the register still occupied and not being consumed is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (sclr) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete && (!data_valid || data_ready)) begin
            data_out   <= shifted;
            data_valid <= 1'b1;
        end else if (complete) begin
            overrun    <= 1'b1;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

    // Sticky framing-error flag, cleared only by reset or sclr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (sclr) begin
            frame_err <= 1'b0;
        end else if (frame_err_set) begin
            frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: one MSB-first and one LSB-first
// instance share all inputs; expected values are hand-computed constants.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclr = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       serial_in = 1'b0;
    logic       data_ready = 1'b0;

    logic [7:0] m_data_out;
    logic       m_data_valid, m_busy, m_overrun, m_frame_err;
    logic [7:0] l_data_out;
    logic       l_data_valid, l_busy, l_overrun, l_frame_err;

    int n_cmp = 0;
    int n_err = 0;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclr       (sclr),
        .en         (en),
        .start      (start),
        .serial_in  (serial_in),
        .data_ready (data_ready),
        .data_out   (m_data_out),
        .data_valid (m_data_valid),
        .busy       (m_busy),
        .overrun    (m_overrun),
        .frame_err  (m_frame_err)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclr       (sclr),
        .en         (en),
        .start      (start),
        .serial_in  (serial_in),
        .data_ready (data_ready),
        .data_out   (l_data_out),
        .data_valid (l_data_valid),
        .busy       (l_busy),
        .overrun    (l_overrun),
        .frame_err  (l_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one strobed bit from a negedge; returns at the following negedge.
    task automatic send_bit(input logic b, input logic st);
        en = 1'b1;
        start = st;
        serial_in = b;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        en = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends a full 8-bit frame; msb selects transmission order, rdy_last
    // raises data_ready only for the completing edge.
    task automatic send_word(input logic [7:0] w, input logic msb, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && rdy_last) data_ready = 1'b1;
            send_bit(msb ? w[7-i] : w[i], (i == 0));
        end
        if (rdy_last) data_ready = 1'b0;
    endtask

    task automatic consume();
        data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic pulse_sclr();
        sclr = 1'b1;
        en = 1'b1;
        start = 1'b1;
        data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sclr = 1'b0;
        en = 1'b0;
        start = 1'b0;
        data_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        // Reset state, with inputs toggling while reset is held.
        en = 1'b1; start = 1'b1; serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", m_data_out, 0);
        check("rst_valid", m_data_valid, 0);
        check("rst_busy", m_busy, 0);
        check("rst_flags", {m_overrun, m_frame_err}, 0);
        en = 1'b0; start = 1'b0; serial_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: 0xA5, MSB first.
        for (int i = 0; i < 8; i++) begin
            send_bit(a5[7-i], (i == 0));
            if (i < 7) check($sformatf("t1_busy_b%0d", i + 1), m_busy, 1);
            if (i == 6) check("t1_valid_early", m_data_valid, 0);
        end
        check("t1_data_out", m_data_out, 8'hA5);
        check("t1_valid", m_data_valid, 1);
        check("t1_busy_after", m_busy, 0);
        consume();
        check("t1_consume_valid", m_data_valid, 0);
        check("t1_consume_hold", m_data_out, 8'hA5);

        // Test 2: 3-cycle stall after bit 4.
        for (int i = 0; i < 4; i++) send_bit(a5[7-i], (i == 0));
        repeat (3) idle_cycle();
        check("t2_stall_busy", m_busy, 1);
        check("t2_stall_valid", m_data_valid, 0);
        for (int i = 4; i < 7; i++) send_bit(a5[7-i], 1'b0);
        check("t2_valid_b7", m_data_valid, 0);
        send_bit(a5[0], 1'b0);
        check("t2_valid", m_data_valid, 1);
        check("t2_data_out", m_data_out, 8'hA5);
        consume();

        // Test 3: overrun when the register is still occupied.
        send_word(8'h3C, 1'b1, 1'b0);
        check("t3_first", m_data_out, 8'h3C);
        send_word(8'hC3, 1'b1, 1'b0);
        check("t3_kept", m_data_out, 8'h3C);
        check("t3_valid", m_data_valid, 1);
        check("t3_overrun", m_overrun, 1);
        consume();
        check("t3_consumed", m_data_valid, 0);
        check("t3_overrun_sticky", m_overrun, 1);
        check("t3_out_hold", m_data_out, 8'h3C);

        // sclr clears everything, even with en/start/data_ready high.
        pulse_sclr();
        check("sclr_overrun", m_overrun, 0);
        check("sclr_busy", m_busy, 0);

        // Test 4: consume and replace on the same edge.
        send_word(8'h3C, 1'b1, 1'b0);
        send_word(8'h81, 1'b1, 1'b1);
        check("t4_data_out", m_data_out, 8'h81);
        check("t4_valid", m_data_valid, 1);
        check("t4_overrun", m_overrun, 0);
        consume();

        // Test 5: mid-frame start, then sclr, then LSB-first reception.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t5_no_err_yet", m_frame_err, 0);
        send_word(8'hF0, 1'b1, 1'b0);
        check("t5_frame_err", m_frame_err, 1);
        check("t5_data_out", m_data_out, 8'hF0);
        check("t5_valid", m_data_valid, 1);
        pulse_sclr();
        check("t5_sclr_out", m_data_out, 0);
        check("t5_sclr_ctl", {m_data_valid, m_busy, m_overrun, m_frame_err}, 0);
        send_word(8'hA5, 1'b0, 1'b0);
        check("t5_lsb_a5", l_data_out, 8'hA5);
        check("t5_lsb_valid", l_data_valid, 1);
        consume();
        send_word(8'h1E, 1'b0, 1'b0);
        check("t5_lsb_1e", l_data_out, 8'h1E);
        check("t5_msb_view_1e", m_data_out, 8'h78);

        // Test 6: asynchronous reset mid-frame, between clock edges.
        for (int i = 0; i < 5; i++) send_bit(a5[7-i], (i == 0));
        check("t6_busy_pre", m_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", m_data_out, 0);
        check("t6_rst_ctl", {m_data_valid, m_busy, m_overrun, m_frame_err}, 0);
        en = 1'b1; start = 1'b1; serial_in = 1'b1; data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_held", {m_data_valid, m_busy}, 0);
        en = 1'b0; start = 1'b0; data_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        check("t6_nostart_valid", m_data_valid, 0);
        check("t6_nostart_busy", m_busy, 0);
        send_word(8'h5A, 1'b1, 1'b0);
        check("t6_recover", m_data_out, 8'h5A);
        check("t6_recover_valid", m_data_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
